// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: RV32M decode constants, dispatcher state and target encodings.
package pcpi_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    RELEASE
  } state_e;

  typedef enum logic {
    TGT_MUL,
    TGT_DIV
  } tgt_e;

endpackage

// File: rtl/pcpi_mdu_decode.sv
// Combinational RV32M claim/target decode; reusable by any PCPI dispatcher.
module pcpi_mdu_decode
  import pcpi_pkg::*;
#(
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic        valid_i,
  input  logic [31:0] insn_i,
  output logic        claim_o,
  output tgt_e        tgt_o
);

  logic is_muldiv;

  always_comb begin
    is_muldiv = (insn_i[6:0] == OPC_OP) && (insn_i[31:25] == F7_MULDIV);
    tgt_o     = insn_i[14] ? TGT_DIV : TGT_MUL;
    // Divide-class encodings are left unclaimed when no divider is fitted.
    claim_o   = valid_i && is_muldiv && (!insn_i[14] || ENABLE_DIV);
  end

endmodule

// File: rtl/pcpi_mdu_dispatch.sv
// PCPI dispatcher routing RV32M instructions to a multiplier or divider coprocessor.
// Optional statistics counters are enabled with `define PCPI_MDU_DISPATCH_STATS_EN.
module pcpi_mdu_dispatch
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ENABLE_DIV     = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_insn,
  input  logic [31:0] cpu_rs1,
  input  logic [31:0] cpu_rs2,
  output logic        cpu_wr,
  output logic [31:0] cpu_rd,
  output logic        cpu_wait,
  output logic        cpu_ready,
  output logic        mul_valid,
  output logic [31:0] mul_insn,
  output logic [31:0] mul_rs1,
  output logic [31:0] mul_rs2,
  input  logic        mul_wr,
  input  logic [31:0] mul_rd,
  input  logic        mul_wait,
  input  logic        mul_ready,
  output logic        div_valid,
  output logic [31:0] div_insn,
  output logic [31:0] div_rs1,
  output logic [31:0] div_rs2,
  input  logic        div_wr,
  input  logic [31:0] div_rd,
  input  logic        div_wait,
  input  logic        div_ready
`ifdef PCPI_MDU_DISPATCH_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [15:0] stat_timeouts,
  output logic [15:0] stat_aborts
`endif
);

  localparam bit          DIV_EN   = (ENABLE_DIV != 0);
  localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_e        state_q, state_d;
  tgt_e          tgt_q, tgt_d;
  logic [31:0]   insn_q, insn_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   rd_q, rd_d;

  logic claim;
  tgt_e claim_tgt;
  logic sel_ready, sel_wr;
  logic [31:0] sel_rd;
  logic issue_evt, timeout_evt, abort_evt;

  // The dispatcher alone owns cpu_wait, so the targets' wait flags are not used.
  logic unused_wait;
  assign unused_wait = mul_wait ^ div_wait;

  pcpi_mdu_decode #(
    .ENABLE_DIV (DIV_EN)
  ) u_decode (
    .valid_i (cpu_valid),
    .insn_i  (cpu_insn),
    .claim_o (claim),
    .tgt_o   (claim_tgt)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    tgt_d       = tgt_q;
    insn_d      = insn_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    issue_evt   = 1'b0;
    timeout_evt = 1'b0;
    abort_evt   = 1'b0;

    // Only the selected target's handshake is honoured.
    sel_ready = (tgt_q == TGT_MUL) ? mul_ready : (DIV_EN && div_ready);
    sel_wr    = (tgt_q == TGT_MUL) ? mul_wr : div_wr;
    sel_rd    = (tgt_q == TGT_MUL) ? mul_rd : div_rd;

    unique case (state_q)
      IDLE: begin
        if (claim) begin
          state_d   = BUSY;
          tgt_d     = claim_tgt;
          insn_d    = cpu_insn;
          rs1_d     = cpu_rs1;
          rs2_d     = cpu_rs2;
          cnt_d     = '0;
          issue_evt = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (sel_ready) begin
          wr_d    = sel_wr;
          rd_d    = sel_rd;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RELEASE;
          timeout_evt = 1'b1;
        end else if (!cpu_valid) begin
          state_d   = IDLE;
          abort_evt = 1'b1;
        end
      end
      DONE:    state_d = RELEASE;
      // Hold off until the core stops presenting the retired instruction.
      RELEASE: if (!cpu_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_valid = (state_q == BUSY) && (tgt_q == TGT_MUL);
    div_valid = DIV_EN && (state_q == BUSY) && (tgt_q == TGT_DIV);
    mul_insn  = mul_valid ? insn_q : '0;
    mul_rs1   = mul_valid ? rs1_q  : '0;
    mul_rs2   = mul_valid ? rs2_q  : '0;
    div_insn  = div_valid ? insn_q : '0;
    div_rs1   = div_valid ? rs1_q  : '0;
    div_rs2   = div_valid ? rs2_q  : '0;
    cpu_wait  = (state_q == BUSY);
    cpu_ready = (state_q == DONE);
    cpu_wr    = cpu_ready && wr_q;
    cpu_rd    = cpu_ready ? rd_q : '0;
  end

  // NOTE: state uses non-blocking assignments and a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      tgt_q   <= TGT_MUL;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

`ifdef PCPI_MDU_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_issued   <= '0;
      stat_timeouts <= '0;
      stat_aborts   <= '0;
    end else begin
      if (issue_evt)   stat_issued   <= stat_issued + 1'b1;
      if (timeout_evt) stat_timeouts <= stat_timeouts + 1'b1;
      if (abort_evt)   stat_aborts   <= stat_aborts + 1'b1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = issue_evt ^ timeout_evt ^ abort_evt;
`endif

endmodule
